// File: rtl/com_pkg.sv
// Shared types and helpers for the processor-to-interpreter stream serializer.
package com_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2,
        WAIT  = 2'd3
    } ser_state_e;

    function automatic int beats_f(input int data_w, input int out_w);
        return data_w / out_w;
    endfunction

endpackage

// File: rtl/com_fifo.sv
// Synchronous word FIFO with registered occupancy, full and empty flags.
module com_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             full_r;
    logic             empty_r;
    logic             pop_s;
    logic             push_s;
    logic [LW-1:0]    level_next_s;

    // Accept a push when full only if a pop frees the slot in the same cycle.
    always_comb begin
        pop_s        = pop && !empty_r;
        push_s       = push && (!full_r || pop_s);
        level_next_s = level_r;
        if (push_s && !pop_s) begin
            level_next_s = level_r + LW'(1);
        end else if (!push_s && pop_s) begin
            level_next_s = level_r - LW'(1);
        end else begin
            level_next_s = level_r;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            level_r <= level_next_s;
            full_r  <= (level_next_s == LW'(DEPTH));
            empty_r <= (level_next_s == LW'(0));
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= push_data;
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;
    assign level    = level_r;

endmodule

// File: rtl/com_stream_serializer.sv
// Captures qualified data-memory read words and streams them to the interpreter
// as strobed OUT_W-bit beats with back-pressure and sticky overflow reporting.
module com_stream_serializer
    import com_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 16,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       com,
    input  logic                       mem_to_reg,
    input  logic [DATA_W-1:0]          read_data,
    input  logic                       out_ready,
    input  logic                       clear_ovf,
    output logic                       clk_out,
    output logic [OUT_W-1:0]           data_out,
    output logic                       word_last,
    output logic                       busy,
    output logic                       full,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int BEATS = beats_f(DATA_W, OUT_W);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    ser_state_e        state_r, state_next_s;
    logic [DW-1:0]     div_cnt_r, div_next_s;
    logic [BW-1:0]     beat_cnt_r, beat_next_s;
    logic [DATA_W-1:0] shift_r, shift_next_s;
    logic              pop_s;
    logic              capture_s;
    logic              div_done_s;
    logic              last_beat_s;
    logic [DATA_W-1:0] fifo_data_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              overflow_r;
    logic              clk_out_r;
    logic              word_last_r;
    logic              busy_r;

    function automatic logic [DATA_W-1:0] advance_f(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0) begin
            return w << OUT_W;
        end else begin
            return w >> OUT_W;
        end
    endfunction

    assign capture_s   = com && mem_to_reg;
    assign div_done_s  = (div_cnt_r == DW'(CLK_DIV - 1));
    assign last_beat_s = (beat_cnt_r == BW'(BEATS - 1));

    com_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (capture_s),
        .push_data (read_data),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (level)
    );

    // Beat sequencing: out_ready is only consulted at beat boundaries.
    always_comb begin
        state_next_s = state_r;
        div_next_s   = div_cnt_r;
        beat_next_s  = beat_cnt_r;
        shift_next_s = shift_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s && out_ready) begin
                    pop_s        = 1'b1;
                    shift_next_s = fifo_data_s;
                    beat_next_s  = BW'(0);
                    div_next_s   = DW'(0);
                    state_next_s = SETUP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP: begin
                if (div_done_s) begin
                    div_next_s   = DW'(0);
                    state_next_s = HOLD;
                end else begin
                    div_next_s = div_cnt_r + DW'(1);
                end
            end
            HOLD: begin
                if (!div_done_s) begin
                    div_next_s = div_cnt_r + DW'(1);
                end else if (!last_beat_s) begin
                    div_next_s = DW'(0);
                    if (out_ready) begin
                        beat_next_s  = beat_cnt_r + BW'(1);
                        shift_next_s = advance_f(shift_r);
                        state_next_s = SETUP;
                    end else begin
                        state_next_s = WAIT;
                    end
                end else if (!fifo_empty_s && out_ready) begin
                    pop_s        = 1'b1;
                    shift_next_s = fifo_data_s;
                    beat_next_s  = BW'(0);
                    div_next_s   = DW'(0);
                    state_next_s = SETUP;
                end else begin
                    div_next_s   = DW'(0);
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (out_ready) begin
                    beat_next_s  = beat_cnt_r + BW'(1);
                    shift_next_s = advance_f(shift_r);
                    div_next_s   = DW'(0);
                    state_next_s = SETUP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state, counters, shift register and registered strobe outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            div_cnt_r   <= DW'(0);
            beat_cnt_r  <= BW'(0);
            shift_r     <= DATA_W'(0);
            clk_out_r   <= 1'b0;
            word_last_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            div_cnt_r   <= div_next_s;
            beat_cnt_r  <= beat_next_s;
            shift_r     <= shift_next_s;
            clk_out_r   <= (state_next_s == HOLD);
            word_last_r <= ((state_next_s == SETUP) || (state_next_s == HOLD)) &&
                           (beat_next_s == BW'(BEATS - 1));
            busy_r      <= (state_next_s != IDLE);
        end
    end

    // Sticky overflow: a dropped capture outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (capture_s && fifo_full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end else if (clear_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign data_out  = (MSB_FIRST != 0) ? shift_r[DATA_W-1 -: OUT_W] : shift_r[OUT_W-1:0];
    assign clk_out   = clk_out_r;
    assign word_last = word_last_r;
    assign busy      = busy_r;
    assign full      = fifo_full_s;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_com_stream_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus; a
// beat-order reference model fills expectation queues checked at each clk_out rise.
module tb_com_stream_serializer;

    localparam int DATA_W  = 32;
    localparam int OUT_W   = 8;
    localparam int DEPTH   = 4;
    localparam int CLK_DIV = 2;
    localparam int BEATS   = DATA_W / OUT_W;
    localparam int LW      = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              com;
    logic              mem_to_reg;
    logic [DATA_W-1:0] read_data;
    logic              out_ready;
    logic              clear_ovf;

    logic              clk_out_m, word_last_m, busy_m, full_m, overflow_m;
    logic [OUT_W-1:0]  data_out_m;
    logic [LW-1:0]     level_m;
    logic              clk_out_l, word_last_l, busy_l, full_l, overflow_l;
    logic [OUT_W-1:0]  data_out_l;
    logic [LW-1:0]     level_l;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int done_words = 0;
    int rise_q[$];
    logic [OUT_W:0] exp_m[$];
    logic [OUT_W:0] exp_l[$];
    logic prev_m = 1'b0;
    logic prev_l = 1'b0;

    com_stream_serializer #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .com(com), .mem_to_reg(mem_to_reg), .read_data(read_data),
        .out_ready(out_ready), .clear_ovf(clear_ovf), .clk_out(clk_out_m), .data_out(data_out_m),
        .word_last(word_last_m), .busy(busy_m), .full(full_m), .overflow(overflow_m), .level(level_m)
    );

    com_stream_serializer #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .com(com), .mem_to_reg(mem_to_reg), .read_data(read_data),
        .out_ready(out_ready), .clear_ovf(clear_ovf), .clk_out(clk_out_l), .data_out(data_out_l),
        .word_last(word_last_l), .busy(busy_l), .full(full_l), .overflow(overflow_l), .level(level_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: beat sequence of a word in each emission order.
    task automatic expect_word(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] t;
        logic lst;
        for (int i = 0; i < BEATS; i++) begin
            lst = (i == BEATS - 1);
            t = w >> (DATA_W - OUT_W * (i + 1));
            exp_m.push_back({lst, t[OUT_W-1:0]});
            t = w >> (OUT_W * i);
            exp_l.push_back({lst, t[OUT_W-1:0]});
        end
    endtask

    task automatic capture(input logic [DATA_W-1:0] w, input bit accepted);
        com = 1'b1;
        mem_to_reg = 1'b1;
        read_data = w;
        if (accepted) expect_word(w);
        @(negedge clk);
        com = 1'b0;
        mem_to_reg = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_drain(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (exp_m.size() == 0 && exp_l.size() == 0 && !busy_m && !busy_l) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("drain", 64'(ok), 64'd1);
    endtask

    // Monitor: pops the scoreboard on each beat strobe rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            exp_m.delete();
            exp_l.delete();
            prev_m <= 1'b0;
            prev_l <= 1'b0;
        end else begin
            if (clk_out_m && !prev_m) begin
                rise_q.push_back(cyc);
                rise_cnt++;
                if (word_last_m) done_words++;
                if (exp_m.size() == 0) check("beat_m_queue", 64'(exp_m.size()), 64'd1);
                else check("beat_m", 64'({word_last_m, data_out_m}), 64'(exp_m.pop_front()));
            end
            if (clk_out_l && !prev_l) begin
                if (exp_l.size() == 0) check("beat_l_queue", 64'(exp_l.size()), 64'd1);
                else check("beat_l", 64'({word_last_l, data_out_l}), 64'(exp_l.pop_front()));
            end
            prev_m <= clk_out_m;
            prev_l <= clk_out_l;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cap;
        int rc;
        int issued;
        int pending;
        logic [DATA_W-1:0] w;

        reset = 1'b0; com = 1'b0; mem_to_reg = 1'b0; read_data = '0;
        out_ready = 1'b0; clear_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs_m", 64'({clk_out_m, data_out_m, word_last_m, busy_m, full_m, overflow_m, level_m}), 64'd0);
        check("reset_outputs_l", 64'({clk_out_l, data_out_l, word_last_l, busy_l, full_l, overflow_l, level_l}), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single word timing.
        out_ready = 1'b1;
        rise_q.delete();
        cap = cyc;
        capture(32'hA1B2C3D4, 1'b1);
        check("single_level", 64'(level_m), 64'd1);
        @(negedge clk);
        check("single_first_beat_m", 64'({clk_out_m, data_out_m}), 64'h0A1);
        check("single_first_beat_l", 64'(data_out_l), 64'hD4);
        wait_cyc(cap + 17);
        check("single_busy_last_hold", 64'(busy_m), 64'd1);
        wait_cyc(cap + 18);
        check("single_busy_done", 64'(busy_m), 64'd0);
        check("single_rise_count", 64'(rise_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < rise_q.size(); i++)
            check("single_rise_time", 64'(rise_q[i]), 64'(cap + 4 + 4 * i));

        // Overflow, clear, set-wins and full push+pop.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) capture($urandom, i < 4);
        check("ovf_level", 64'(level_m), 64'd4);
        check("ovf_full", 64'(full_m), 64'd1);
        check("ovf_flag", 64'({overflow_m, overflow_l}), 64'd3);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        check("ovf_clear", 64'(overflow_m), 64'd0);
        clear_ovf = 1'b1;
        capture($urandom, 1'b0);
        clear_ovf = 1'b0;
        check("ovf_set_wins", 64'(overflow_m), 64'd1);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        check("ovf_clear2", 64'(overflow_m), 64'd0);
        out_ready = 1'b1;
        capture(32'h5566_7788, 1'b1);
        check("full_pushpop_level", 64'({full_m, level_m}), 64'({1'b1, 3'd4}));
        check("full_pushpop_ovf", 64'(overflow_m), 64'd0);
        wait_drain(300);

        // Back-pressure after beat 2 starts.
        cap = cyc;
        capture(32'hA1B2C3D4, 1'b1);
        wait_cyc(cap + 6);
        out_ready = 1'b0;
        wait_cyc(cap + 10);
        for (int i = 0; i < 3; i++) begin
            check("wait_hold_m", 64'({busy_m, clk_out_m, data_out_m}), 64'h2B2);
            if (i < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("resume_m", 64'({clk_out_m, data_out_m}), 64'h0C3);
        check("resume_l", 64'(data_out_l), 64'hB2);
        wait_drain(100);

        // Single qualifiers never capture.
        rc = rise_cnt;
        com = 1'b1; mem_to_reg = 1'b0;
        repeat (3) @(negedge clk);
        com = 1'b0; mem_to_reg = 1'b1;
        repeat (3) @(negedge clk);
        mem_to_reg = 1'b0;
        repeat (4) @(negedge clk);
        check("qual_level", 64'(level_m), 64'd0);
        check("qual_no_strobe", 64'(rise_cnt), 64'(rc));

        // Reset in the middle of beat 3.
        cap = cyc;
        capture(32'h1122_3344, 1'b1);
        wait_cyc(cap + 12);
        #2 reset = 1'b0;
        #1;
        check("midreset_m", 64'({clk_out_m, data_out_m, word_last_m, busy_m, full_m, overflow_m, level_m}), 64'd0);
        check("midreset_l", 64'({clk_out_l, data_out_l, word_last_l, busy_l, full_l, overflow_l, level_l}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rc = rise_cnt;
        repeat (30) @(negedge clk);
        check("postreset_level", 64'({busy_m, level_m}), 64'd0);
        check("postreset_no_strobe", 64'(rise_cnt), 64'(rc));

        // Two queued words stream back to back.
        rise_q.delete();
        cap = cyc;
        capture(32'hA1B2C3D4, 1'b1);
        capture(32'h0F1E2D3C, 1'b1);
        wait_cyc(cap + 18);
        check("b2b_busy", 64'(busy_m), 64'd1);
        wait_drain(100);
        check("b2b_rise_count", 64'(rise_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < rise_q.size(); i++)
            check("b2b_rise_time", 64'(rise_q[i]), 64'(cap + 4 + 4 * i));

        // Randomized traffic, paced so the FIFO never overflows.
        issued = done_words;
        for (int n = 0; n < 1500; n++) begin
            pending = issued - done_words;
            com = 1'($urandom_range(0, 1));
            mem_to_reg = 1'($urandom_range(0, 1));
            if (com && mem_to_reg && pending >= DEPTH) mem_to_reg = 1'b0;
            read_data = $urandom;
            if (com && mem_to_reg) begin
                expect_word(read_data);
                issued++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            clear_ovf = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        com = 1'b0; mem_to_reg = 1'b0; clear_ovf = 1'b0; out_ready = 1'b1;
        wait_drain(600);
        check("rand_no_overflow", 64'({overflow_m, overflow_l}), 64'd0);
        check("rand_level", 64'(level_m), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/com_stream_serializer.md
# com_stream_serializer

Parametrised successor to the CPU-to-interpreter communication path. It captures data-memory read words flagged by the pipelined processor's COM/MemtoReg qualifiers into a FIFO. It serialises each word into OUT_W-bit beats with a generated sample strobe (clk_out) for the external interpreter, with receiver back-pressure and overflow reporting. It sits beside the processor and data memory in the top level, driven from ReadData.

## Interface
- DATA_W, 32: captured word width; must be a multiple of OUT_W.
- OUT_W, 8: output beat width.
- DEPTH, 16: FIFO depth in words; power of 2, ≥2.
- CLK_DIV, 4: cycles clk_out stays low, then cycles it stays high, per beat; ≥1.
- MSB_FIRST, 1: 1 = most-significant beat first; 0 = least-significant first.
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- com  in  1  COM flag from processor.
- mem_to_reg  in  1  MemtoReg (M stage) from processor.
- read_data  in  DATA_W  data-memory read word.
- out_ready  in  1  interpreter can accept a beat.
- clear_ovf  in  1  synchronous clear of the overflow flag.
- clk_out  out  1  beat strobe; interpreter samples data_out on its rising edge.
- data_out  out  OUT_W  current beat.
- word_last  out  1  current beat is the final beat of its word.
- busy  out  1  serializer not in IDLE.
- full  out  1  FIFO holds DEPTH words.
- overflow  out  1  sticky: a capture was dropped.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Capture condition: com && mem_to_reg in a cycle. Each qualifying cycle writes one read_data word, including back-to-back cycles. com alone or mem_to_reg alone does not write.
- Capture while full with no pop in the same cycle: the word is dropped and overflow is set. overflow clears only on reset or clear_ovf. If a set and clear_ovf occur in the same cycle, the set wins.
- Capture while full in the same cycle as a pop: the write is accepted, and level stays DEPTH.
- BEATS = DATA_W/OUT_W. The popped word loads a shift register. After each beat the register shifts by OUT_W toward the emit side selected by MSB_FIRST.
- States (enum in package): IDLE, SETUP (clk_out=0, data_out stable, CLK_DIV cycles), HOLD (clk_out=1, CLK_DIV cycles), WAIT (clk_out=0, data_out held).
  - IDLE→SETUP: FIFO not empty && out_ready. Pop happens on this edge.
  - SETUP→HOLD: after CLK_DIV cycles.
  - HOLD end, more beats, out_ready=1: →SETUP with the next beat.
  - HOLD end, more beats, out_ready=0: →WAIT.
  - WAIT→SETUP: when out_ready=1.
  - HOLD end, last beat, FIFO not empty && out_ready: pop and go straight to SETUP (back-to-back words).
  - HOLD end, last beat, otherwise: →IDLE.
- out_ready is sampled only at beat boundaries. A beat in progress always completes.
- word_last is high throughout SETUP/HOLD of the final beat.

## Timing
- Reset (asynchronous, immediate): every output is 0, FIFO is emptied, state is IDLE, level=0.
- Capture in cycle N: level increments from N+1. If the serializer is IDLE and out_ready=1, the pop occurs at the end of N+1.
  - data_out shows the first beat from N+2, with clk_out low.
  - clk_out rises at N+2+CLK_DIV.
- Each beat occupies 2·CLK_DIV cycles. data_out changes only at SETUP entry, so it is stable ≥CLK_DIV cycles before every clk_out rise.
- full and level are registered and reflect writes and pops of the previous cycle.
- A reset asserted mid-word discards the partial word; nothing resumes after reset.

## Structure
- Package com_pkg holds the serializer state enum typedef and a BEATS localparam helper function.
- One sub-module, com_fifo: a synchronous FIFO parameterised by width and depth, with push/pop/full/empty/level. Simultaneous push+pop is legal when full or empty+push.
- The serializer FSM, beat counter, divider counter and shift register live in com_stream_serializer.

## Test plan
Defaults for all scenarios: DATA_W=32, OUT_W=8, DEPTH=4, CLK_DIV=2 unless stated otherwise.

- **Single word.** out_ready=1, capture 0xA1B2C3D4 at cycle N → data_out A1,B2,C3,D4 starting N+2, 4 cycles each. clk_out rises at N+4,N+8,N+12,N+16. word_last is high only on D4. busy returns to 0 after the last HOLD.
- **Overflow.** out_ready=0, capture 5 words on back-to-back cycles → level=4, full=1, overflow=1, 5th word never emitted. A clear_ovf pulse returns overflow to 0.
- **Back-pressure.** Drop out_ready after beat B2 starts → B2 completes, then WAIT holds clk_out=0 and data_out=B2. Raising out_ready resumes with C3 in SETUP the next cycle.
- **Qualifiers.** com=1, mem_to_reg=0 for 3 cycles, then com=0, mem_to_reg=1 → level stays 0 and clk_out never toggles.
- **Reset mid-word.** Assert reset during beat C3 → all outputs 0 asynchronously. After release, level=0 and there is no further output.
- **Beat order.** MSB_FIRST=0, 0xA1B2C3D4 → D4,C3,B2,A1. With two queued words, the second word's first beat follows the first word's last HOLD with no IDLE cycle.
